// File: rtl/ysyx_23060236_scoreboard_pkg.sv
// Shared sizing constants for the register-hazard scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_23060236_scoreboard_pkg;
    localparam int NR_REG    = 16;
    localparam int REG_IDX_W = $clog2(NR_REG);
    localparam int CNT_W     = 2;
    localparam int TOT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
endpackage

// File: rtl/ysyx_23060236_sb_cnt.sv
// Pending-write counter for one architectural register; never wraps.
// Latency: events at edge t are reflected in nz/full from t+1; err is same-cycle combinational.
// Backpressure: none; overflow holds the count and underflow clamps to zero, both flagged on err.
module ysyx_23060236_sb_cnt
    import ysyx_23060236_scoreboard_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec_w,
    input  logic dec_s,
    output logic nz,
    output logic full,
    output logic err
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   up;
    logic [CNT_W:0]   dn;
    logic [CNT_W:0]   diff;
    logic             under;
    logic             over;

    // Combine all three events arithmetically before range-checking.
    assign up    = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
    assign dn    = {{CNT_W{1'b0}}, dec_w} + {{CNT_W{1'b0}}, dec_s};
    assign under = up < dn;
    assign diff  = up - dn;
    assign over  = !under && (diff > {1'b0, CNT_MAX});

    assign nz   = cnt != '0;
    assign full = cnt == CNT_MAX;
    assign err  = under | over;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (under) begin
            cnt <= '0;
        end else if (!over) begin
            cnt <= diff[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/ysyx_23060236_scoreboard.sv
// Register-hazard scoreboard: counts outstanding writes per register and stalls IDU on RAW/full.
// Latency: issue at edge t marks busy from t+1; writeback/squash at edge t clears from t+1 (no bypass).
// Backpressure: stall is combinational and feeds ~idu_ready; ignoring it only risks a flagged overflow.
module ysyx_23060236_scoreboard
    import ysyx_23060236_scoreboard_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic                 dec_need_rs1,
    input  logic                 dec_need_rs2,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic                 dec_reg_wen,
    input  logic                 issue_fire,
    input  logic                 squash_valid,
    input  logic [REG_IDX_W-1:0] squash_rd,
    input  logic                 squash_wen,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_reg_wen,
    output logic                 stall,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [TOT_W-1:0]     inflight,
    output logic                 sb_err
);
    logic [NR_REG-1:0] nz;
    logic [NR_REG-1:0] full_v;
    logic [NR_REG-1:0] err_v;
    logic              any_inc;
    logic              any_w;
    logic              any_s;
    logic [TOT_W:0]    tot_up;
    logic [TOT_W:0]    tot_dn;
    logic [TOT_W:0]    tot_diff;
    logic              full;

    // x0 is hardwired zero, so it never holds a pending write.
    assign nz[0]     = 1'b0;
    assign full_v[0] = 1'b0;
    assign err_v[0]  = 1'b0;

    for (genvar r = 1; r < NR_REG; r++) begin : g_cnt
        ysyx_23060236_sb_cnt u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (issue_fire & dec_reg_wen & (dec_rd == REG_IDX_W'(r))),
            .dec_w (wb_valid & wb_reg_wen & (wb_rd == REG_IDX_W'(r))),
            .dec_s (squash_valid & squash_wen & (squash_rd == REG_IDX_W'(r))),
            .nz    (nz[r]),
            .full  (full_v[r]),
            .err   (err_v[r])
        );
    end

    assign rs1_busy = dec_need_rs1 & nz[dec_rs1];
    assign rs2_busy = dec_need_rs2 & nz[dec_rs2];
    assign full     = dec_reg_wen & full_v[dec_rd];
    assign stall    = rs1_busy | rs2_busy | full;

    // Each event source carries at most one register per cycle, so the total moves by at most +1/-2.
    assign any_inc  = issue_fire & dec_reg_wen & (dec_rd != '0);
    assign any_w    = wb_valid & wb_reg_wen & (wb_rd != '0);
    assign any_s    = squash_valid & squash_wen & (squash_rd != '0);
    assign tot_up   = {1'b0, inflight} + {{TOT_W{1'b0}}, any_inc};
    assign tot_dn   = {{TOT_W{1'b0}}, any_w} + {{TOT_W{1'b0}}, any_s};
    assign tot_diff = tot_up - tot_dn;

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
            sb_err   <= 1'b0;
        end else begin
            if (tot_up < tot_dn) begin
                inflight <= '0;
            end else if (tot_diff > {1'b0, TOT_MAX}) begin
                inflight <= TOT_MAX;
            end else begin
                inflight <= tot_diff[TOT_W-1:0];
            end
            sb_err <= sb_err | (|err_v);
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_scoreboard.sv
// Directed bench for the register-hazard scoreboard with hand-computed expectations.
// Latency: n/a. Backpressure: n/a.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_ysyx_23060236_scoreboard;
    logic       clock;
    logic       reset;
    logic [3:0] dec_rs1;
    logic [3:0] dec_rs2;
    logic       dec_need_rs1;
    logic       dec_need_rs2;
    logic [3:0] dec_rd;
    logic       dec_reg_wen;
    logic       issue_fire;
    logic       squash_valid;
    logic [3:0] squash_rd;
    logic       squash_wen;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic       wb_reg_wen;
    logic       stall;
    logic       rs1_busy;
    logic       rs2_busy;
    logic [3:0] inflight;
    logic       sb_err;

    int checks = 0;
    int errors = 0;

    ysyx_23060236_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_need_rs1 (dec_need_rs1),
        .dec_need_rs2 (dec_need_rs2),
        .dec_rd       (dec_rd),
        .dec_reg_wen  (dec_reg_wen),
        .issue_fire   (issue_fire),
        .squash_valid (squash_valid),
        .squash_rd    (squash_rd),
        .squash_wen   (squash_wen),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_wen   (wb_reg_wen),
        .stall        (stall),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .inflight     (inflight),
        .sb_err       (sb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dec_rs1 = '0; dec_rs2 = '0; dec_need_rs1 = 0; dec_need_rs2 = 0;
        dec_rd = '0; dec_reg_wen = 0; issue_fire = 0;
        squash_valid = 0; squash_rd = '0; squash_wen = 0;
        wb_valid = 0; wb_rd = '0; wb_reg_wen = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] rd);
        idle();
        dec_rd = rd; dec_reg_wen = 1; issue_fire = 1;
        tick();
        idle();
    endtask

    task automatic wb(input logic [3:0] rd);
        idle();
        wb_valid = 1; wb_rd = rd; wb_reg_wen = 1;
        tick();
        idle();
    endtask

    task automatic probe(input logic [3:0] rs1, input logic [3:0] rs2);
        dec_rs1 = rs1; dec_need_rs1 = 1;
        dec_rs2 = rs2; dec_need_rs2 = 1;
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // 1: reset state
        dec_rs1 = 4'd5; dec_need_rs1 = 1; #1;
        chk("rst_stall", stall, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_sb_err", sb_err, 0);
        tick();

        // 2: RAW hazard on x5, cleared one cycle after writeback
        issue(4'd5);
        dec_rs2 = 4'd5; dec_need_rs2 = 1; #1;
        chk("raw_stall_t1", stall, 1);
        chk("raw_rs2_busy_t1", rs2_busy, 1);
        chk("raw_inflight_t1", inflight, 1);
        tick();
        tick();
        wb_valid = 1; wb_rd = 4'd5; wb_reg_wen = 1; #1;
        chk("raw_no_bypass", stall, 1);
        tick();
        idle();
        dec_rs2 = 4'd5; dec_need_rs2 = 1; #1;
        chk("raw_stall_t4", stall, 0);
        chk("raw_inflight_t4", inflight, 0);
        idle();

        // need_rs gating: busy register but not read
        issue(4'd6);
        dec_rs1 = 4'd6; dec_need_rs1 = 0; #1;
        chk("need_gate", rs1_busy, 0);
        wb(4'd6);

        // 3: same-cycle issue + writeback on x3
        issue(4'd3);
        dec_rd = 4'd3; dec_reg_wen = 1; issue_fire = 1;
        wb_valid = 1; wb_rd = 4'd3; wb_reg_wen = 1;
        tick();
        idle();
        probe(4'd3, 4'd0);
        chk("iw_rs1_busy", rs1_busy, 1);
        chk("iw_inflight", inflight, 1);
        wb(4'd3);
        probe(4'd3, 4'd0);
        chk("iw_cleared", rs1_busy, 0);
        chk("iw_inflight0", inflight, 0);
        idle();

        // 4: fill x7 to capacity, then force an overflow
        issue(4'd7);
        issue(4'd7);
        dec_rd = 4'd7; dec_reg_wen = 1; #1;
        chk("fill2_not_full", stall, 0);
        issue(4'd7);
        dec_rd = 4'd7; dec_reg_wen = 1; #1;
        chk("full_stall", stall, 1);
        chk("full_inflight", inflight, 3);
        chk("full_no_err", sb_err, 0);
        issue_fire = 1;
        tick();
        idle();
        chk("ovf_sb_err", sb_err, 1);
        wb(4'd7);
        wb(4'd7);
        probe(4'd7, 4'd0);
        chk("ovf_cnt_after2wb", rs1_busy, 1);
        idle();
        wb(4'd7);
        probe(4'd7, 4'd0);
        chk("ovf_cnt_after3wb", rs1_busy, 0);
        chk("ovf_err_sticky", sb_err, 1);
        idle();

        // reset mid-operation clears everything
        issue(4'd8);
        reset = 1;
        tick();
        reset = 0;
        probe(4'd8, 4'd0);
        chk("midrst_busy", rs1_busy, 0);
        chk("midrst_inflight", inflight, 0);
        chk("midrst_sb_err", sb_err, 0);
        idle();

        // 5: squash, then an extra writeback underflows
        issue(4'd9);
        probe(4'd9, 4'd0);
        chk("sq_busy_before", rs1_busy, 1);
        idle();
        squash_valid = 1; squash_rd = 4'd9; squash_wen = 1;
        tick();
        idle();
        probe(4'd9, 4'd9);
        chk("sq_busy_after", stall, 0);
        chk("sq_inflight", inflight, 0);
        chk("sq_no_err", sb_err, 0);
        idle();
        wb(4'd9);
        probe(4'd9, 4'd0);
        chk("udf_sb_err", sb_err, 1);
        chk("udf_busy", rs1_busy, 0);
        chk("udf_inflight_clamp", inflight, 0);
        idle();

        // inc + wb + squash on one register nets to -1
        issue(4'd9);
        dec_rd = 4'd9; dec_reg_wen = 1; issue_fire = 1;
        wb_valid = 1; wb_rd = 4'd9; wb_reg_wen = 1;
        squash_valid = 1; squash_rd = 4'd9; squash_wen = 1;
        tick();
        idle();
        probe(4'd9, 4'd0);
        chk("iws_busy", rs1_busy, 0);
        chk("iws_inflight", inflight, 0);
        idle();

        // 6: x0 traffic is invisible
        reset = 1;
        tick();
        reset = 0;
        issue(4'd2);
        issue(4'd0);
        wb_valid = 1; wb_rd = 4'd0; wb_reg_wen = 1;
        squash_valid = 1; squash_rd = 4'd0; squash_wen = 1;
        tick();
        idle();
        probe(4'd0, 4'd0);
        dec_rd = 4'd0; dec_reg_wen = 1; #1;
        chk("x0_stall", stall, 0);
        chk("x0_rs1_busy", rs1_busy, 0);
        chk("x0_rs2_busy", rs2_busy, 0);
        chk("x0_inflight", inflight, 1);
        chk("x0_sb_err", sb_err, 0);
        probe(4'd2, 4'd0);
        chk("x2_still_busy", rs1_busy, 1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
